// File: rtl/bcd_time_counter_if.sv
// Control/status bundle of one BCD time-counter stage. The master drives the
// step/preset controls and the slave (the counter) returns the count and flags.
interface bcd_time_counter_if #(
  parameter int DIGITS = 2
);
  logic                   en;
  logic                   up;
  logic                   load;
  logic [DIGITS-1:0][3:0] load_val;
  logic [DIGITS-1:0][3:0] bcd;
  logic                   tc;
  logic                   zero;
  logic                   load_err;

  modport master (
    output en, up, load, load_val,
    input  bcd, tc, zero, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, tc, zero, load_err
  );
endinterface

// File: rtl/bcd_time_counter.sv
// Parametrised BCD up/down time counter: synchronous preset with range check,
// wrap or saturate at the bounds, and a one-cycle terminal-count pulse for cascading.

module bcd_digit_step (
  input  logic       cin,
  input  logic       up,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          q    = 4'd0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q    = 4'd9;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_time_counter #(
  parameter int DIGITS   = 2,
  parameter int MODULUS  = 60,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               clear_n,
  bcd_time_counter_if.slave  bus
);
  function automatic logic [DIGITS-1:0][3:0] to_bcd(input int v);
    logic [DIGITS-1:0][3:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = 4'(t % 10);
      t    = t / 10;
    end
    return r;
  endfunction

  localparam logic [DIGITS-1:0][3:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [DIGITS-1:0][3:0] cnt, cnt_nxt, stepped;
  logic [DIGITS:0]        carry;
  logic                   tc_q, tc_nxt, err_q, err_nxt, zero_q;
  logic                   load_ok, is_max, at_bound;

  // Ripple carry/borrow chain, one digit slice per lane.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_step u_step (
      .cin  (carry[i]),
      .up   (bus.up),
      .d    (cnt[i]),
      .q    (stepped[i]),
      .cout (carry[i+1])
    );
  end

  // Legal BCD orders the same as its decimal value, so the range check
  // can compare nibble vectors directly once every nibble is <= 9.
  always_comb begin
    load_ok = (bus.load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++)
      if (bus.load_val[i] > 4'd9) load_ok = 1'b0;
  end

  // Borrow out of the top digit happens only from all-zeros, i.e. the lower bound.
  assign is_max   = (cnt == MAX_BCD);
  assign at_bound = bus.up ? is_max : carry[DIGITS];

  always_comb begin
    cnt_nxt = cnt;
    tc_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (bus.load) begin
      if (load_ok) cnt_nxt = bus.load_val;
      else         err_nxt = 1'b1;
    end else if (bus.en) begin
      if (at_bound) begin
        if (!SATURATE) begin
          cnt_nxt = bus.up ? '0 : MAX_BCD;
          tc_nxt  = 1'b1;
        end
      end else begin
        cnt_nxt = stepped;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt    <= '0;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      tc_q   <= tc_nxt;
      err_q  <= err_nxt;
      zero_q <= (cnt_nxt == '0);
    end
  end

  assign bus.bcd      = cnt;
  assign bus.tc       = tc_q;
  assign bus.load_err = err_q;
  assign bus.zero     = zero_q;
endmodule
